vote_booth_arbiter: RTL and testbench

Session controller and round-robin arbiter that shares the single ballot tally bank among NUM_BOOTHS voting booths. Sequences the session open/close/clear lifecycle, grants one booth at a time, and forwards exactly one validated candidate code per grant to the tally bank over a valid/ready handshake. Sits between the booth front-ends and the tally/result datapath.

---
 rtl/vote_pkg.sv | 26 ++
 rtl/vote_rr_arbiter.sv | 41 ++++
 rtl/vote_booth_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_vote_booth_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// ---------------------------------------------------------------------------
// vote_pkg
// Shared types and constants for the voting-booth arbiter.
//   vote_state_t : session / arbitration FSM states
//   CAND_W_DEF   : default candidate code width
//   NO_CAND      : candidate code meaning "no selection yet"
//   ptr_inc()    : round-robin pointer increment with wrap
// ---------------------------------------------------------------------------
package vote_pkg;

   typedef enum logic [2:0] {
      CLOSED = 3'd0,
      IDLE   = 3'd1,
      GRANT  = 3'd2,
      ISSUE  = 3'd3,
      CLR    = 3'd4
   } vote_state_t;

   localparam int CAND_W_DEF = 4;
   localparam int NO_CAND    = 0;

   function automatic int ptr_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/vote_rr_arbiter.sv
// ---------------------------------------------------------------------------
// vote_rr_arbiter
// Purely combinational round-robin pick: searches req upward starting at
// ptr, wrapping past N-1, and returns the first requester found.
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  search start index
//   any  out 1   at least one request present
//   pick out N   one-hot of the chosen requester (0 when none)
//   idx  out IW  index of the chosen requester (0 when none)
// ---------------------------------------------------------------------------
module vote_rr_arbiter
   import vote_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [N-1:0]  pick,
   output logic [IW-1:0] idx
);

   always_comb begin
      int k;
      k    = 0;
      any  = 1'b0;
      pick = '0;
      idx  = '0;
      for (int i = 0; i < N; i++) begin
         k = (int'(ptr) + i) % N;
         if (!any && req[k]) begin
            any     = 1'b1;
            pick[k] = 1'b1;
            idx     = IW'(k);
         end
      end
   end

endmodule

// File: rtl/vote_booth_arbiter.sv
// ---------------------------------------------------------------------------
// vote_booth_arbiter
// Session controller plus round-robin arbiter sharing one tally bank among
// NUM_BOOTHS booths. One candidate code is forwarded per grant over a
// valid/ready handshake.
// Optional feature macro: BOOTH_TIMEOUT_EN (revokes a grant whose booth
// holds code 0 for TIMEOUT cycles; without it timeout_err is tied low).
// Ports:
//   clk, Power (sync active-high reset)
//   Open / Close / Clear        session lifecycle levels
//   booth_req / booth_cand      per-booth request and candidate code
//   booth_grant / booth_ack     one-hot grant, one-cycle accept pulse
//   vote_valid/_cand/_booth     vote to tally bank, vote_ready accepts
//   tally_clr                   clear pulse to tally bank
//   session_open, timeout_err   status
// ---------------------------------------------------------------------------
module vote_booth_arbiter
   import vote_pkg::*;
#(
   parameter int NUM_BOOTHS = 4,
   parameter int CAND_W     = CAND_W_DEF,
   parameter int TIMEOUT    = 255,
   parameter int TO_W       = 8
) (
   input  logic                           clk,
   input  logic                           Power,
   input  logic                           Open,
   input  logic                           Close,
   input  logic                           Clear,
   input  logic [NUM_BOOTHS-1:0]          booth_req,
   input  logic [NUM_BOOTHS*CAND_W-1:0]   booth_cand,
   output logic [NUM_BOOTHS-1:0]          booth_grant,
   output logic [NUM_BOOTHS-1:0]          booth_ack,
   output logic                           vote_valid,
   output logic [CAND_W-1:0]              vote_cand,
   output logic [$clog2(NUM_BOOTHS)-1:0]  vote_booth,
   input  logic                           vote_ready,
   output logic                           tally_clr,
   output logic                           session_open,
   output logic                           timeout_err
);

   localparam int IW = $clog2(NUM_BOOTHS);

   vote_state_t          state;
   logic [IW-1:0]        rr_ptr;
   logic [IW-1:0]        grant_idx;
   logic                 close_pend;

   logic                 pick_any;
   logic [NUM_BOOTHS-1:0] pick_onehot;
   logic [IW-1:0]        pick_idx;
   logic [CAND_W-1:0]    granted_cand;
   logic [IW-1:0]        rr_next;

   vote_rr_arbiter #(.N(NUM_BOOTHS), .IW(IW)) u_rr (
      .req  (booth_req),
      .ptr  (rr_ptr),
      .any  (pick_any),
      .pick (pick_onehot),
      .idx  (pick_idx)
   );

   assign granted_cand = booth_cand[int'(grant_idx)*CAND_W +: CAND_W];
   // After a served (or timed-out) grant the search restarts just past it.
   assign rr_next      = IW'(ptr_inc(int'(grant_idx), NUM_BOOTHS));

`ifdef BOOTH_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;
`endif

   always_ff @(posedge clk) begin
      if (Power) begin
         state        <= CLOSED;
         rr_ptr       <= '0;
         grant_idx    <= '0;
         close_pend   <= 1'b0;
         booth_grant  <= '0;
         booth_ack    <= '0;
         vote_valid   <= 1'b0;
         vote_cand    <= '0;
         vote_booth   <= '0;
         tally_clr    <= 1'b0;
         session_open <= 1'b0;
         timeout_err  <= 1'b0;
`ifdef BOOTH_TIMEOUT_EN
         to_cnt       <= '0;
`endif
      end else begin
         // Pulse outputs default low every cycle.
         booth_ack   <= '0;
         tally_clr   <= 1'b0;
         timeout_err <= 1'b0;

         if (Clear) begin
            // Clear wins in every state. A vote whose handshake lands on
            // this same edge has already been taken by the tally bank, but
            // the booth gets no ack.
            state        <= CLR;
            tally_clr    <= 1'b1;
            rr_ptr       <= '0;
            close_pend   <= 1'b0;
            booth_grant  <= '0;
            vote_valid   <= 1'b0;
            vote_cand    <= '0;
            vote_booth   <= '0;
            session_open <= 1'b0;
         end else begin
            case (state)
               CLOSED: begin
                  if (Open) begin
                     state        <= IDLE;
                     session_open <= 1'b1;
                  end
               end

               IDLE: begin
                  if (Close || close_pend) begin
                     state        <= CLOSED;
                     close_pend   <= 1'b0;
                     session_open <= 1'b0;
                  end else if (pick_any) begin
                     state       <= GRANT;
                     booth_grant <= pick_onehot;
                     grant_idx   <= pick_idx;
`ifdef BOOTH_TIMEOUT_EN
                     to_cnt      <= '0;
`endif
                  end
               end

               GRANT: begin
                  if (Close) close_pend <= 1'b1;
                  if (!booth_req[grant_idx]) begin
                     // Booth walked away: release without moving the pointer.
                     state       <= IDLE;
                     booth_grant <= '0;
                  end else if (granted_cand != CAND_W'(NO_CAND)) begin
                     state      <= ISSUE;
                     vote_valid <= 1'b1;
                     vote_cand  <= granted_cand;
                     vote_booth <= grant_idx;
                  end
`ifdef BOOTH_TIMEOUT_EN
                  else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                     state       <= IDLE;
                     booth_grant <= '0;
                     timeout_err <= 1'b1;
                     rr_ptr      <= rr_next;
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
`endif
               end

               ISSUE: begin
                  if (Close) close_pend <= 1'b1;
                  if (vote_ready) begin
                     state       <= IDLE;
                     booth_ack   <= booth_grant;
                     booth_grant <= '0;
                     vote_valid  <= 1'b0;
                     vote_cand   <= '0;
                     vote_booth  <= '0;
                     rr_ptr      <= rr_next;
                  end
               end

               CLR: begin
                  state <= CLOSED;
               end

               default: begin
                  state        <= CLOSED;
                  booth_grant  <= '0;
                  vote_valid   <= 1'b0;
                  session_open <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vote_booth_arbiter.sv
module tb_vote_booth_arbiter;

   localparam int NB = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          Power, Open, Close, Clear;
   logic [NB-1:0] booth_req;
   logic [NB*CW-1:0] booth_cand;
   logic [NB-1:0] booth_grant, booth_ack;
   logic          vote_valid;
   logic [CW-1:0] vote_cand;
   logic [1:0]    vote_booth;
   logic          vote_ready;
   logic          tally_clr, session_open, timeout_err;

   int checks = 0;
   int errors = 0;

   vote_booth_arbiter #(.NUM_BOOTHS(NB), .CAND_W(CW), .TIMEOUT(8), .TO_W(8)) dut (
      .clk          (clk),
      .Power        (Power),
      .Open         (Open),
      .Close        (Close),
      .Clear        (Clear),
      .booth_req    (booth_req),
      .booth_cand   (booth_cand),
      .booth_grant  (booth_grant),
      .booth_ack    (booth_ack),
      .vote_valid   (vote_valid),
      .vote_cand    (vote_cand),
      .vote_booth   (vote_booth),
      .vote_ready   (vote_ready),
      .tally_clr    (tally_clr),
      .session_open (session_open),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running required finished");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cand(input int k, input logic [CW-1:0] v);
      booth_cand[k*CW +: CW] = v;
   endtask

   task automatic test_reset();
      Power = 1'b1; Open = 1'b1; Close = 1'b0; Clear = 1'b0;
      booth_req = '1; booth_cand = 16'h4321; vote_ready = 1'b1;
      step(); step();
      checks++;
      if (booth_grant !== 4'b0 || booth_ack !== 4'b0) begin
         errors++; $display("FAIL reset_grant_ack: got %b/%b required 0000/0000", booth_grant, booth_ack);
      end
      checks++;
      if (vote_valid !== 1'b0 || vote_cand !== 4'd0 || vote_booth !== 2'd0) begin
         errors++; $display("FAIL reset_vote: got v=%b c=%0d b=%0d required 0/0/0", vote_valid, vote_cand, vote_booth);
      end
      checks++;
      if (tally_clr !== 1'b0 || session_open !== 1'b0 || timeout_err !== 1'b0) begin
         errors++; $display("FAIL reset_status: got %b%b%b required 000", tally_clr, session_open, timeout_err);
      end
      Power = 1'b0; Open = 1'b0; booth_req = '0; booth_cand = '0;
      step();
      checks++;
      if (session_open !== 1'b0 || booth_grant !== 4'b0) begin
         errors++; $display("FAIL closed_ignores_req: got open=%b grant=%b required 0/0000", session_open, booth_grant);
      end
   endtask

   task automatic test_basic_vote();
      Open = 1'b1; step(); Open = 1'b0;
      checks++;
      if (session_open !== 1'b1) begin
         errors++; $display("FAIL open_session: got %b required 1", session_open);
      end
      booth_req = 4'b0100; set_cand(2, 4'd5); vote_ready = 1'b1;
      step();
      checks++;
      if (booth_grant !== 4'b0100 || vote_valid !== 1'b0) begin
         errors++; $display("FAIL basic_grant: got %b v=%b required 0100 v=0", booth_grant, vote_valid);
      end
      step();
      checks++;
      if (vote_valid !== 1'b1 || vote_cand !== 4'd5 || vote_booth !== 2'd2) begin
         errors++; $display("FAIL basic_vote: got v=%b c=%0d b=%0d required 1/5/2", vote_valid, vote_cand, vote_booth);
      end
      $display("vote: booth %0d cand %0d", vote_booth, vote_cand);
      step();
      checks++;
      if (booth_ack !== 4'b0100 || booth_grant !== 4'b0 || vote_valid !== 1'b0) begin
         errors++; $display("FAIL basic_ack: got ack=%b grant=%b v=%b required 0100/0000/0", booth_ack, booth_grant, vote_valid);
      end
      booth_req = '0;
      step();
      checks++;
      if (booth_ack !== 4'b0 || booth_grant !== 4'b0) begin
         errors++; $display("FAIL basic_ack_pulse: got ack=%b grant=%b required 0000/0000", booth_ack, booth_grant);
      end
   endtask

   task automatic test_round_robin();
      logic [NB-1:0] exp_g;
      // Fresh session so the pointer starts at 0.
      Power = 1'b1; step(); Power = 1'b0;
      Open = 1'b1; step(); Open = 1'b0;
      for (int k = 0; k < NB; k++) set_cand(k, CW'(k + 1));
      booth_req = '1; vote_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         exp_g = '0;
         exp_g[n % NB] = 1'b1;
         step();
         checks++;
         if (booth_grant !== exp_g) begin
            errors++; $display("FAIL rr_grant_%0d: got %b required %b", n, booth_grant, exp_g);
         end
         step();
         checks++;
         if (vote_valid !== 1'b1 || vote_booth !== 2'(n % NB) || vote_cand !== CW'((n % NB) + 1)) begin
            errors++; $display("FAIL rr_vote_%0d: got v=%b b=%0d c=%0d required 1/%0d/%0d", n, vote_valid, vote_booth, vote_cand, n % NB, (n % NB) + 1);
         end
         $display("vote: booth %0d cand %0d", vote_booth, vote_cand);
         step();
         checks++;
         if (booth_ack !== exp_g) begin
            errors++; $display("FAIL rr_ack_%0d: got %b required %b", n, booth_ack, exp_g);
         end
      end
      booth_req = '0;
      step();
   endtask

   task automatic test_stall();
      int bad;
      booth_req = 4'b0010; set_cand(1, 4'd7); vote_ready = 1'b0;
      step();
      checks++;
      if (booth_grant !== 4'b0010) begin
         errors++; $display("FAIL stall_grant: got %b required 0010", booth_grant);
      end
      step();
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (vote_valid !== 1'b1 || vote_cand !== 4'd7 || vote_booth !== 2'd1 || booth_ack !== 4'b0) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL stall_hold: got %0d unstable cycles required 0", bad);
      end
      vote_ready = 1'b1;
      step();
      checks++;
      if (booth_ack !== 4'b0010 || vote_valid !== 1'b0) begin
         errors++; $display("FAIL stall_ack: got ack=%b v=%b required 0010/0", booth_ack, vote_valid);
      end
      $display("vote: booth 1 cand 7 accepted after stall");
      booth_req = '0;
      step();
      checks++;
      if (booth_ack !== 4'b0) begin
         errors++; $display("FAIL stall_single_ack: got %b required 0000", booth_ack);
      end
   endtask

   task automatic test_close_during_issue();
      booth_req = 4'b1000; set_cand(3, 4'd9); vote_ready = 1'b0;
      step(); step();
      Close = 1'b1;
      step();
      Close = 1'b0;
      checks++;
      if (vote_valid !== 1'b1 || vote_cand !== 4'd9 || session_open !== 1'b1) begin
         errors++; $display("FAIL close_inflight: got v=%b c=%0d open=%b required 1/9/1", vote_valid, vote_cand, session_open);
      end
      vote_ready = 1'b1;
      step();
      checks++;
      if (booth_ack !== 4'b1000) begin
         errors++; $display("FAIL close_ack: got %b required 1000", booth_ack);
      end
      $display("vote: booth 3 cand 9 completed under close");
      booth_req = 4'b0001; set_cand(0, 4'd2);
      step();
      checks++;
      if (session_open !== 1'b0 || booth_grant !== 4'b0) begin
         errors++; $display("FAIL close_to_closed: got open=%b grant=%b required 0/0000", session_open, booth_grant);
      end
      step(); step();
      checks++;
      if (booth_grant !== 4'b0 || vote_valid !== 1'b0) begin
         errors++; $display("FAIL closed_no_grant: got grant=%b v=%b required 0000/0", booth_grant, vote_valid);
      end
      booth_req = '0;
   endtask

   task automatic test_clear();
      Open = 1'b1; step(); Open = 1'b0;
      // One vote from booth 1 moves the pointer to 2.
      booth_req = 4'b0010; set_cand(1, 4'd3); vote_ready = 1'b1;
      step(); step(); step();
      $display("vote: booth 1 cand 3 before clear");
      set_cand(1, 4'd0);
      step();
      checks++;
      if (booth_grant !== 4'b0010) begin
         errors++; $display("FAIL clear_regrant: got %b required 0010", booth_grant);
      end
      step();
      checks++;
      if (vote_valid !== 1'b0 || booth_grant !== 4'b0010) begin
         errors++; $display("FAIL grant_wait_cand0: got v=%b grant=%b required 0/0010", vote_valid, booth_grant);
      end
      Clear = 1'b1;
      step();
      checks++;
      if (tally_clr !== 1'b1 || booth_grant !== 4'b0 || vote_valid !== 1'b0 || session_open !== 1'b0) begin
         errors++; $display("FAIL clear_enter: got clr=%b grant=%b v=%b open=%b required 1/0000/0/0", tally_clr, booth_grant, vote_valid, session_open);
      end
      step();
      checks++;
      if (tally_clr !== 1'b1) begin
         errors++; $display("FAIL clear_held: got %b required 1", tally_clr);
      end
      Clear = 1'b0;
      step();
      checks++;
      if (tally_clr !== 1'b0 || session_open !== 1'b0) begin
         errors++; $display("FAIL clear_exit: got clr=%b open=%b required 0/0", tally_clr, session_open);
      end
      Open = 1'b1; step(); Open = 1'b0;
      booth_req = 4'b1010; set_cand(1, 4'd4); set_cand(3, 4'd6);
      step();
      checks++;
      if (booth_grant !== 4'b0010) begin
         errors++; $display("FAIL clear_ptr_zero: got %b required 0010", booth_grant);
      end
      booth_req = '0;
      step();
      checks++;
      if (booth_grant !== 4'b0 || vote_valid !== 1'b0 || booth_ack !== 4'b0) begin
         errors++; $display("FAIL release_no_vote: got grant=%b v=%b ack=%b required 0000/0/0000", booth_grant, vote_valid, booth_ack);
      end
   endtask

`ifdef BOOTH_TIMEOUT_EN
   task automatic test_timeout();
      int bad;
      Power = 1'b1; step(); Power = 1'b0;
      Open = 1'b1; step(); Open = 1'b0;
      booth_req = 4'b0110; set_cand(1, 4'd0); set_cand(2, 4'd5); vote_ready = 1'b0;
      step();
      bad = 0;
      for (int i = 0; i < 7; i++) begin
         if (booth_grant !== 4'b0010 || timeout_err !== 1'b0) bad++;
         step();
      end
      checks++;
      if (bad != 0 || booth_grant !== 4'b0010) begin
         errors++; $display("FAIL timeout_hold: got %0d bad cycles grant=%b required 0/0010", bad, booth_grant);
      end
      step();
      checks++;
      if (timeout_err !== 1'b1 || booth_grant !== 4'b0) begin
         errors++; $display("FAIL timeout_pulse: got err=%b grant=%b required 1/0000", timeout_err, booth_grant);
      end
      step();
      checks++;
      if (timeout_err !== 1'b0 || booth_grant !== 4'b0100) begin
         errors++; $display("FAIL timeout_next: got err=%b grant=%b required 0/0100", timeout_err, booth_grant);
      end
      $display("timeout: booth 1 revoked, booth 2 granted");
      booth_req = '0;
      step();
   endtask
`else
   task automatic test_no_timeout();
      int bad;
      booth_req = 4'b0010; set_cand(1, 4'd0);
      step();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (booth_grant !== 4'b0010 || timeout_err !== 1'b0 || vote_valid !== 1'b0) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL no_timeout_wait: got %0d bad cycles required 0", bad);
      end
      booth_req = '0;
      step();
      checks++;
      if (booth_grant !== 4'b0) begin
         errors++; $display("FAIL no_timeout_release: got %b required 0000", booth_grant);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_vote();
      test_round_robin();
      test_stall();
      test_close_during_issue();
      test_clear();
`ifdef BOOTH_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
